// File: rtl/pingpong_tile_fb.sv
// pingpong_tile_fb: double-buffered tile framebuffer for the visualizer.
// The renderer fills the back bank via valid/ready. Banks swap only at the
// start of vertical blank. The scan side returns tile data two cycles after
// hc/vc are presented. An optional sweep zeroes the new back bank after a swap.
module pingpong_tile_fb #(
   parameter int DATA_W        = 8,
   parameter int H_TILE        = 40,
   parameter int V_TILE        = 24,
   parameter int COLS          = 16,
   parameter int ROWS          = 20,
   parameter int H_ACTIVE      = 640,
   parameter int V_ACTIVE      = 480,
   parameter int CLEAR_ON_SWAP = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [$clog2(COLS)-1:0] wr_col,
   input  logic [$clog2(ROWS)-1:0] wr_row,
   input  logic [DATA_W-1:0]       wr_data,
   output logic                    wr_err,
   input  logic                    frame_done,
   input  logic [9:0]              hc,
   input  logic [9:0]              vc,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    rd_valid,
   output logic                    bank_rd,
   output logic                    swap_pending,
   output logic                    overrun
);

   localparam int DEPTH = COLS * ROWS;
   localparam int AW    = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_WRITE,
      S_PENDING,
      S_CLEAR
   } state_t;

   // two banks; bank_rd selects the displayed one, the other is the back bank
   logic [DATA_W-1:0] mem0 [DEPTH];
   logic [DATA_W-1:0] mem1 [DEPTH];

   state_t            state_q, state_d;
   logic              bank_rd_q, bank_rd_d;
   logic              swap_pending_q, swap_pending_d;
   logic              overrun_q, overrun_d;
   logic              wr_ready_q, wr_ready_d;
   logic              wr_err_q, wr_err_d;
   logic [AW-1:0]     clr_cnt_q, clr_cnt_d;

   logic [AW-1:0]     rd_addr_q, rd_addr_d;
   logic              rd_bank_q, rd_bank_d;
   logic              rd_act_q, rd_act_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;

   logic              wr_fire;
   logic              wr_in_range;
   logic [AW-1:0]     wr_addr;
   logic              swap_evt;
   logic              mem_we;
   logic [AW-1:0]     mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   // Write-side decode: handshake, range check, and the RAM write port mux
   always_comb begin
      wr_fire     = wr_valid && wr_ready_q;
      wr_in_range = (int'(wr_col) < COLS) && (int'(wr_row) < ROWS);
      wr_addr     = AW'(int'(wr_row) * COLS + int'(wr_col));
      swap_evt    = swap_pending_q && (int'(vc) == V_ACTIVE) && (hc == 10'd0);
      mem_we      = 1'b0;
      mem_waddr   = wr_addr;
      mem_wdata   = wr_data;
      if (state_q == S_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_cnt_q;
         mem_wdata = '0;
      end else if (wr_fire && wr_in_range) begin
         mem_we    = 1'b1;
      end
   end

   // Next-state logic for the write/pending/clear controller
   always_comb begin
      state_d        = state_q;
      bank_rd_d      = bank_rd_q;
      swap_pending_d = swap_pending_q;
      overrun_d      = overrun_q;
      wr_ready_d     = wr_ready_q;
      clr_cnt_d      = clr_cnt_q;
      wr_err_d       = wr_fire && !wr_in_range;
      case (state_q)
         S_WRITE: begin
            wr_ready_d = 1'b1;
            // swap_pending is only registered here, so a frame_done landing on
            // the vblank point waits for the following vblank
            if (frame_done) begin
               state_d        = S_PENDING;
               swap_pending_d = 1'b1;
               wr_ready_d     = 1'b0;
            end
         end
         S_PENDING: begin
            wr_ready_d = 1'b0;
            if (frame_done) overrun_d = 1'b1;
            if (swap_evt) begin
               bank_rd_d      = ~bank_rd_q;
               swap_pending_d = 1'b0;
               if (CLEAR_ON_SWAP != 0) begin
                  state_d   = S_CLEAR;
                  clr_cnt_d = '0;
               end else begin
                  state_d    = S_WRITE;
                  wr_ready_d = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            wr_ready_d = 1'b0;
            if (frame_done) overrun_d = 1'b1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == AW'(DEPTH - 1)) begin
               clr_cnt_d  = '0;
               state_d    = S_WRITE;
               wr_ready_d = 1'b1;
            end
         end
         default: begin
            state_d    = S_WRITE;
            wr_ready_d = 1'b0;
         end
      endcase
   end

   // Controller state and its registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_WRITE;
         bank_rd_q      <= 1'b0;
         swap_pending_q <= 1'b0;
         overrun_q      <= 1'b0;
         wr_ready_q     <= 1'b0;
         wr_err_q       <= 1'b0;
         clr_cnt_q      <= '0;
      end else begin
         state_q        <= state_d;
         bank_rd_q      <= bank_rd_d;
         swap_pending_q <= swap_pending_d;
         overrun_q      <= overrun_d;
         wr_ready_q     <= wr_ready_d;
         wr_err_q       <= wr_err_d;
         clr_cnt_q      <= clr_cnt_d;
      end
   end

   // Back-bank RAM writes: renderer data in WRITE, zero sweep in CLEAR
   always_ff @(posedge clk) begin
      if (mem_we && bank_rd_q)  mem0[mem_waddr] <= mem_wdata;
      if (mem_we && !bank_rd_q) mem1[mem_waddr] <= mem_wdata;
   end

   // Scan pipeline: stage 1 tile address and bank latch, stage 2 RAM read
   always_comb begin
      rd_act_d   = (int'(hc) < H_ACTIVE) && (int'(vc) < V_ACTIVE);
      rd_addr_d  = '0;
      if (rd_act_d) rd_addr_d = AW'((int'(vc) / V_TILE) * COLS + int'(hc) / H_TILE);
      rd_bank_d  = bank_rd_q;
      rd_valid_d = rd_act_q;
      rd_data_d  = '0;
      if (rd_act_q) rd_data_d = rd_bank_q ? mem1[rd_addr_q] : mem0[rd_addr_q];
   end

   // Scan pipeline registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_addr_q  <= '0;
         rd_bank_q  <= 1'b0;
         rd_act_q   <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_addr_q  <= rd_addr_d;
         rd_bank_q  <= rd_bank_d;
         rd_act_q   <= rd_act_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign wr_ready     = wr_ready_q;
   assign wr_err       = wr_err_q;
   assign bank_rd      = bank_rd_q;
   assign swap_pending = swap_pending_q;
   assign overrun      = overrun_q;
   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;

endmodule
